xor_frame_distance: RTL and testbench
=====================================

XOR_FRAME_DISTANCE -- requirements
Module: xor_frame_distance

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 16, giving the bits per frame; the legal range is 2..255.
REQ-002 The block SHALL have parameter CNT_W, default 5, giving the count width; the value SHALL satisfy 2^CNT_W > FRAME_LEN.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  in_bit is presented this cycle.
REQ-006 in_bit  input  1  mismatch bit (A^B result from the upstream XOR stage).
REQ-007 in_ready  output  1  block accepts in_bit this cycle.
REQ-008 out_valid  output  1  frame result held on out_dist/out_zero.
REQ-009 out_ready  input  1  downstream consumes the result this cycle.
REQ-010 out_dist  output  CNT_W  count of 1 bits in the completed frame (Hamming distance).
REQ-011 out_zero  output  1  completed frame contained no mismatches.
REQ-012 busy  output  1  a frame is partially accumulated.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-014 A transfer on the input SHALL occur only when in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-016 IDLE: on transfer -> ACCUM; cnt=in_bit; idx=1.
REQ-017 ACCUM: each transfer SHALL add in_bit to cnt and increment idx; with in_valid=0, cnt, idx and state SHALL be held with no timeout.
REQ-018 ACCUM: on the transfer that makes idx equal FRAME_LEN -> HOLD; out_dist=final cnt; out_zero=(final cnt==0); out_valid=1 the next cycle.
REQ-019 Latency SHALL be one cycle from the last-bit transfer to out_valid=1.
REQ-020 HOLD: out_valid=1, and out_dist/out_zero SHALL stay stable until the output handshake; in_valid/in_bit SHALL be ignored.
REQ-021 HOLD: with out_valid=1 and out_ready=1 -> IDLE next cycle; cnt=0; idx=0; out_valid=0; the first bit of the next frame is accepted no earlier than that IDLE cycle.
REQ-022 out_ready asserted outside HOLD SHALL have no effect.
REQ-023 busy SHALL be 1 exactly in ACCUM.
REQ-024 cnt SHALL never wrap: max value FRAME_LEN < 2^CNT_W.
REQ-025 When out_valid=0, out_dist and out_zero SHALL retain their last values; they are don't-care to consumers.

Reset
REQ-026 When rst_n=0 at a rising clk edge, state=IDLE, cnt=0, idx=0, out_valid=0, out_dist=0, out_zero=0, busy=0, regardless of state.
REQ-027 Reset mid-frame or in HOLD SHALL discard the partial or held result; no out_valid pulse SHALL follow.
REQ-028 During reset in_ready SHALL read 1, which is its IDLE value; transfers in a reset cycle SHALL be ignored.

Configuration
REQ-029 With macro XOR_FRAME_PARITY_EN defined, the block SHALL add output out_parity (1 bit) = XOR of all frame bits (LSB of final cnt), registered with out_dist, reset to 0, and stable in HOLD.
REQ-030 Without XOR_FRAME_PARITY_EN, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (FRAME_LEN=16, CNT_W=5)
REQ-031 Feed 16 bits 0xA5A5 back-to-back with out_ready=1 -> one cycle after the 16th bit, out_valid=1, out_dist=8, out_zero=0 (out_parity=0 if enabled).
REQ-032 Feed 16 zero bits -> out_dist=0, out_zero=1; then 16 ones -> out_dist=16, out_zero=0 (out_parity=0).
REQ-033 Feed 10 bits, drop in_valid for 5 cycles, feed 6 more (7 ones total) -> busy=1 throughout the gap; out_dist=7.
REQ-034 Hold out_ready=0 for 4 cycles in HOLD while driving in_valid=1 -> in_ready=0, out_dist unchanged, no bits counted; after out_ready=1, a new 16-bit frame counts correctly.
REQ-035 Apply rst_n=0 for 1 cycle after 9 bits -> all outputs reset, no out_valid; the next 16-bit frame of 3 ones gives out_dist=3.

Source files
------------

// File: rtl/xor_frame_distance.sv
// Counts mismatch bits over a FRAME_LEN-bit frame and holds the Hamming distance until the consumer takes it.
// Optional out_parity output is enabled by defining XOR_FRAME_PARITY_EN.
module xor_frame_distance #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_dist,
  output logic             out_zero,
`ifdef XOR_FRAME_PARITY_EN
  output logic             out_parity,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic             accept_q;
  logic [CNT_W-1:0] cnt_add;
  logic [CNT_W-1:0] idx_inc;

  assign cnt_add = cnt + CNT_W'(in_bit);
  assign idx_inc = idx + CNT_W'(1);

  // Reset forces the IDLE-state ready value even before the first reset edge lands.
  assign in_ready = accept_q | ~rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      accept_q  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_dist  <= '0;
      out_zero  <= 1'b0;
`ifdef XOR_FRAME_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // FRAME_LEN >= 2, so the first bit can never complete a frame.
          if (in_valid) begin
            state <= ACCUM;
            cnt   <= CNT_W'(in_bit);
            idx   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            cnt <= cnt_add;
            idx <= idx_inc;
            if (idx_inc == LAST_IDX) begin
              state     <= HOLD;
              busy      <= 1'b0;
              accept_q  <= 1'b0;
              out_valid <= 1'b1;
              out_dist  <= cnt_add;
              out_zero  <= (cnt_add == '0);
`ifdef XOR_FRAME_PARITY_EN
              out_parity <= cnt_add[0];
`endif
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            accept_q  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          idx       <= '0;
          accept_q  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_frame_distance.sv
// Randomized and directed bench for xor_frame_distance against a queue-based frame model.
module tb_xor_frame_distance;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_dist;
  logic             out_zero;
  logic             busy;
`ifdef XOR_FRAME_PARITY_EN
  logic             out_parity;
`endif

  xor_frame_distance #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dist  (out_dist),
    .out_zero  (out_zero),
`ifdef XOR_FRAME_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the frame in progress, plus the held result.
  int q_bits[$];
  logic exp_valid = 1'b0;
  int   exp_dist  = 0;
  logic exp_zero  = 1'b0;
  logic exp_par   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic rdy);
    int ones;
    rst_n     = r;
    in_valid  = v;
    in_bit    = b;
    out_ready = rdy;
    if (!r) begin
      q_bits.delete();
      exp_valid = 1'b0;
      exp_dist  = 0;
      exp_zero  = 1'b0;
      exp_par   = 1'b0;
    end else if (exp_valid) begin
      if (rdy) exp_valid = 1'b0;
    end else if (v) begin
      q_bits.push_back(int'(b));
      if (q_bits.size() == FRAME_LEN) begin
        ones = 0;
        foreach (q_bits[i]) ones += q_bits[i];
        exp_dist  = ones;
        exp_zero  = (ones == 0);
        exp_par   = ((ones % 2) == 1);
        exp_valid = 1'b1;
        q_bits.delete();
      end
    end
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("in_ready",  32'(in_ready),  32'(!exp_valid || !rst_n));
    check("busy",      32'(busy),      32'(q_bits.size() > 0));
    check("out_dist",  32'(out_dist),  32'(exp_dist));
    check("out_zero",  32'(out_zero),  32'(exp_zero));
`ifdef XOR_FRAME_PARITY_EN
    check("out_parity", 32'(out_parity), 32'(exp_par));
`endif
  endtask

  // Feeds n bits of pat, MSB of the n-bit field first.
  task automatic feed(input logic [15:0] pat, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, pat[n-1-i], rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);

    feed(16'hA5A5, 16, 1'b1);
    idle(2);

    feed(16'h0000, 16, 1'b1);
    idle(2);
    feed(16'hFFFF, 16, 1'b1);
    idle(2);

    feed(16'h02A1, 10, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    feed(16'h0007, 6, 1'b1);
    idle(2);

    feed(16'h00FF, 16, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    feed(16'h1234, 16, 1'b1);
    idle(2);

    feed(16'h01FF, 9, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    feed(16'h0007, 16, 1'b1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
